// File: rtl/bcd_digit_incrementor.sv
// Single BCD digit incrementor with registered result, decimal carry and
// illegal-code flag; one stage of a ripple-registered multi-digit counter.
module bcd_digit_incrementor (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] bcd_in,
    input  logic       inc,
    output logic [3:0] bcd_out,
    output logic       carry,
    output logic       invalid
);

    logic [3:0] bcd_d, bcd_q;
    logic       carry_d, carry_q;
    logic       invalid_d, invalid_q;

    // Codes 10-15 are flagged and never carry, so a corrupt digit cannot
    // ripple a bogus increment into the next stage of the chain.
    always_comb begin
        bcd_d     = 4'd0;
        carry_d   = 1'b0;
        invalid_d = 1'b0;
        if (bcd_in > 4'd9) begin
            invalid_d = 1'b1;
        end else if (inc) begin
            if (bcd_in == 4'd9) begin
                carry_d = 1'b1;
            end else begin
                bcd_d = bcd_in + 4'd1;
            end
        end else begin
            bcd_d = bcd_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_q     <= 4'd0;
            carry_q   <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            bcd_q     <= bcd_d;
            carry_q   <= carry_d;
            invalid_q <= invalid_d;
        end
    end

    assign bcd_out = bcd_q;
    assign carry   = carry_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_digit_incrementor.sv
// Scoreboard bench for bcd_digit_incrementor: the driver pushes the expected
// result of each captured digit, a monitor pops and compares one cycle later.
module tb_bcd_digit_incrementor;

    typedef struct {
        logic [3:0] digit;
        logic       carry;
        logic       invalid;
    } expect_t;

    logic       clk;
    logic       resetN;
    logic [3:0] bcdIn;
    logic       incIn;
    logic [3:0] bcdOut;
    logic       carryOut;
    logic       invalidOut;

    expect_t expectQ[$];
    int      totalChecks = 0;
    int      passedChecks = 0;

    bcd_digit_incrementor dut (
        .clk     (clk),
        .reset_n (resetN),
        .bcd_in  (bcdIn),
        .inc     (incIn),
        .bcd_out (bcdOut),
        .carry   (carryOut),
        .invalid (invalidOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Decimal view of the digit: add, then split into units and tens.
    function automatic expect_t refModel(input int digit, input int incr);
        expect_t e;
        int sum;
        if (digit > 9) begin
            e.digit = 4'd0;
            e.carry = 1'b0;
            e.invalid = 1'b1;
        end else begin
            sum = digit + incr;
            e.digit = 4'(sum % 10);
            e.carry = (sum / 10) != 0;
            e.invalid = 1'b0;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        totalChecks++;
        if (actual == expected) begin
            passedChecks++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int digit, input int incr);
        @(negedge clk);
        #1;
        bcdIn = 4'(digit);
        incIn = incr[0];
        @(posedge clk);
        expectQ.push_back(refModel(digit, incr));
    endtask

    task automatic drainQueue();
        int budget;
        budget = 0;
        while (expectQ.size() != 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (expectQ.size() != 0) begin
            checkOutput("drain_timeout", expectQ.size(), 0);
        end
        #1;
    endtask

    // Monitor: every cycle the DUT presents a fresh registered result.
    always @(negedge clk) begin
        expect_t e;
        if (expectQ.size() != 0) begin
            e = expectQ.pop_front();
            checkOutput("bcd_out", int'(bcdOut), int'(e.digit));
            checkOutput("carry", int'(carryOut), int'(e.carry));
            checkOutput("invalid", int'(invalidOut), int'(e.invalid));
        end
    end

    initial begin
        resetN = 1'b0;
        bcdIn = 4'd7;
        incIn = 1'b1;
        #2;
        checkOutput("reset_bcd_out", int'(bcdOut), 0);
        checkOutput("reset_carry", int'(carryOut), 0);
        checkOutput("reset_invalid", int'(invalidOut), 0);
        @(negedge clk);
        checkOutput("reset_hold_bcd_out", int'(bcdOut), 0);
        #1;
        resetN = 1'b1;

        applyStimulus(7, 1);

        for (int d = 0; d <= 9; d++) applyStimulus(d, 1);
        for (int d = 0; d <= 9; d++) applyStimulus(d, 0);
        for (int d = 10; d <= 15; d++) begin
            applyStimulus(d, 0);
            applyStimulus(d, 1);
        end
        applyStimulus(3, 1);

        for (int n = 0; n < 4; n++) applyStimulus(5, 1);

        for (int n = 0; n < 200; n++) applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));

        applyStimulus(9, 1);
        drainQueue();
        checkOutput("pre_reset_carry", int'(carryOut), 1);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("async_reset_carry", int'(carryOut), 0);
        checkOutput("async_reset_bcd_out", int'(bcdOut), 0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checkOutput("reset_held_carry", int'(carryOut), 0);
            checkOutput("reset_held_bcd_out", int'(bcdOut), 0);
        end
        #1;
        resetN = 1'b1;

        applyStimulus(8, 1);
        applyStimulus(9, 1);
        applyStimulus(0, 0);
        drainQueue();

        $display("[TB] %0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
